snell_numerator: RTL and testbench

- Upstream stage of `division`. Computes the Snell's-law numerator a = n1·sin(θ1), which feeds the divider's `a` port; n2 goes to `b`.
- Inputs: θ1 as an integer angle in degrees and n1 as an unsigned Q3.10 value.
- Output: a 13-bit Q3.10 product with a one-cycle valid pulse.
- Method: sine from an internal 91-entry ROM, then an iterative shift-add multiply.

---
 rtl/snell_numerator.sv | 161 ++++++++++++++++
 tb/tb_snell_numerator.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/snell_numerator.sv
// Snell numerator: y = n1 * sin(theta) in Q3.10, using a 91-entry sine ROM and an 11-step shift-add multiply.
// Latency: start sampled at edge E0 -> valid high for one cycle after edge E0+12 (the error path has the same timing).
// Backpressure: none; start is only taken in IDLE, and start while busy is dropped. Build option SNELL_ROUND_EN selects round-half-up instead of truncation.
module snell_numerator #(
  parameter int W       = 13,
  parameter int ANG_W   = 7,
  parameter int MAX_ANG = 90
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ANG_W-1:0] theta,
  input  logic [W-1:0]     n1,
  output logic             busy,
  output logic             valid,
  output logic             ang_err,
  output logic [W-1:0]     y
);

  localparam int FRAC = 10;
  localparam int SW   = 11;
  localparam int AW   = 24;
  localparam logic [3:0]       LAST_BIT = 4'(FRAC);
  localparam logic [ANG_W-1:0] MAX_A    = ANG_W'(MAX_ANG);
`ifdef SNELL_ROUND_EN
  localparam logic [AW-1:0] RND = AW'(1) << (FRAC - 1);
`else
  localparam logic [AW-1:0] RND = '0;
`endif

  typedef enum logic [1:0] {IDLE, LOOKUP, MUL} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     n1_q, n1_d;
  logic [ANG_W-1:0] theta_q, theta_d;
  logic             err_q, err_d;
  logic [SW-1:0]    sine_q, sine_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [W-1:0]     y_q, y_d;
  logic             valid_q, valid_d;
  logic             ang_err_q, ang_err_d;
  logic             busy_q, busy_d;
  logic [AW-1:0]    addend;
  logic [AW-1:0]    acc_sum;

  // round(sin(a deg) * 1024); out-of-range angles read as zero
  function automatic logic [SW-1:0] sine_rom(input int unsigned a);
    logic [SW-1:0] r;
    case (a)
      0: r = 11'd0;     1: r = 11'd18;    2: r = 11'd36;    3: r = 11'd54;    4: r = 11'd71;
      5: r = 11'd89;    6: r = 11'd107;   7: r = 11'd125;   8: r = 11'd143;   9: r = 11'd160;
      10: r = 11'd178;  11: r = 11'd195;  12: r = 11'd213;  13: r = 11'd230;  14: r = 11'd248;
      15: r = 11'd265;  16: r = 11'd282;  17: r = 11'd299;  18: r = 11'd316;  19: r = 11'd333;
      20: r = 11'd350;  21: r = 11'd367;  22: r = 11'd384;  23: r = 11'd400;  24: r = 11'd416;
      25: r = 11'd433;  26: r = 11'd449;  27: r = 11'd465;  28: r = 11'd481;  29: r = 11'd496;
      30: r = 11'd512;  31: r = 11'd527;  32: r = 11'd543;  33: r = 11'd558;  34: r = 11'd573;
      35: r = 11'd587;  36: r = 11'd602;  37: r = 11'd616;  38: r = 11'd630;  39: r = 11'd644;
      40: r = 11'd658;  41: r = 11'd672;  42: r = 11'd685;  43: r = 11'd698;  44: r = 11'd711;
      45: r = 11'd724;  46: r = 11'd737;  47: r = 11'd749;  48: r = 11'd761;  49: r = 11'd773;
      50: r = 11'd784;  51: r = 11'd796;  52: r = 11'd807;  53: r = 11'd818;  54: r = 11'd828;
      55: r = 11'd839;  56: r = 11'd849;  57: r = 11'd859;  58: r = 11'd868;  59: r = 11'd878;
      60: r = 11'd887;  61: r = 11'd896;  62: r = 11'd904;  63: r = 11'd912;  64: r = 11'd920;
      65: r = 11'd928;  66: r = 11'd935;  67: r = 11'd943;  68: r = 11'd949;  69: r = 11'd956;
      70: r = 11'd962;  71: r = 11'd968;  72: r = 11'd974;  73: r = 11'd979;  74: r = 11'd984;
      75: r = 11'd989;  76: r = 11'd994;  77: r = 11'd998;  78: r = 11'd1002; 79: r = 11'd1005;
      80: r = 11'd1008; 81: r = 11'd1011; 82: r = 11'd1014; 83: r = 11'd1016; 84: r = 11'd1018;
      85: r = 11'd1020; 86: r = 11'd1022; 87: r = 11'd1023; 88: r = 11'd1023; 89: r = 11'd1024;
      90: r = 11'd1024;
      default: r = '0;
    endcase
    return r;
  endfunction

  // partial product for the current sine bit, LSB first
  always_comb begin
    addend  = sine_q[cnt_q] ? ({{(AW-W){1'b0}}, n1_q} << cnt_q) : '0;
    acc_sum = acc_q + addend;
  end

  // next-state and datapath control
  always_comb begin
    state_d   = state_q;
    n1_d      = n1_q;
    theta_d   = theta_q;
    err_d     = err_q;
    sine_d    = sine_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    y_d       = y_q;
    ang_err_d = ang_err_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          n1_d    = n1;
          theta_d = theta;
          err_d   = theta > MAX_A;
          busy_d  = 1'b1;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        // Bad angles also pass through here with a zero sine so both paths share one latency.
        sine_d  = err_q ? '0 : sine_rom(32'(theta_q));
        acc_d   = '0;
        cnt_d   = '0;
        state_d = MUL;
      end
      MUL: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_BIT) begin
          // acc never reaches bit 23, so dropping the top bit after the shift loses nothing
          y_d       = W'((acc_sum + RND) >> FRAC);
          valid_d   = 1'b1;
          ang_err_d = err_q;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      n1_q      <= '0;
      theta_q   <= '0;
      err_q     <= 1'b0;
      sine_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      y_q       <= '0;
      valid_q   <= 1'b0;
      ang_err_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      n1_q      <= n1_d;
      theta_q   <= theta_d;
      err_q     <= err_d;
      sine_q    <= sine_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      y_q       <= y_d;
      valid_q   <= valid_d;
      ang_err_q <= ang_err_d;
      busy_q    <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign valid   = valid_q;
  assign ang_err = ang_err_q;
  assign y       = y_q;

endmodule

// File: tb/tb_snell_numerator.sv
`timescale 1ns/1ps
module tb_snell_numerator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [6:0]  theta;
  logic [12:0] n1;
  logic        busy, valid, ang_err;
  logic [12:0] y;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 0;

  always #5 clk = ~clk;

  snell_numerator dut (
    .clk(clk), .rst(rst), .start(start), .theta(theta), .n1(n1),
    .busy(busy), .valid(valid), .ang_err(ang_err), .y(y)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference: sine rounded to 1/1024, then exact product scaled back by 1024
  function automatic int model_sine(input int th);
    real s;
    s = $sin(th * 3.14159265358979 / 180.0);
    return $rtoi(s * 1024.0 + 0.5);
  endfunction

  function automatic int model_y(input int th, input int n);
    longint p;
    if (th > 90) return 0;
    p = longint'(n) * longint'(model_sine(th));
`ifdef SNELL_ROUND_EN
    p = p + 512;
`endif
    return int'(p / 1024);
  endfunction

  // transaction-level model: accept when idle, deliver 12 edges later
  logic        m_busy, m_valid, m_err, m_perr;
  logic [12:0] m_y;
  int          m_left, m_res;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 0; m_valid <= 0; m_err <= 0; m_y <= 0; m_left <= 0; m_res <= 0; m_perr <= 0;
    end else begin
      m_valid <= 0;
      if (m_busy) begin
        if (m_left == 1) begin
          m_busy <= 0; m_valid <= 1; m_y <= 13'(m_res); m_err <= m_perr;
        end
        m_left <= m_left - 1;
      end else if (start) begin
        m_busy <= 1; m_left <= 12;
        m_res  <= model_y(int'(theta), int'(n1));
        m_perr <= (theta > 7'd90);
      end
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("sb_busy", busy, m_busy);
      chk("sb_valid", valid, m_valid);
      chk("sb_y", y, m_y);
      chk("sb_ang_err", ang_err, m_err);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin tick(); n++; end
    if (busy) chk("idle_timeout", busy, 0);
  endtask

  // called 1 ns after a rising edge; returns 1 ns after edge E0
  task automatic issue(input int th, input int n);
    theta = 7'(th); n1 = 13'(n); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_one(input string nm, input int th, input int n, input int ey, input int ee);
    int lat, bc;
    wait_idle();
    issue(th, n);
    bc = busy ? 1 : 0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (valid) begin lat = k; break; end
      if (busy) bc++;
    end
    chk({nm, "_latency"}, lat, 12);
    chk({nm, "_busy_cycles"}, bc, 12);
    chk({nm, "_y"}, y, ey);
    chk({nm, "_ang_err"}, ang_err, ee);
    tick();
    chk({nm, "_valid_drop"}, valid, 0);
    chk({nm, "_y_hold"}, y, ey);
  endtask

  initial begin
    int v1, v2, nv, y1, y2, lat;
    rst = 1'b1; start = 1'b0; theta = '0; n1 = '0;
    #2 rst = 1'b0;
    #20;
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_ang_err", ang_err, 0);
    chk("rst_y", y, 0);
    cmp_en = 1;
    tick();
    rst = 1'b1;
    tick();

    // pin the reference model to hand-computed points
    chk("model_sin30", model_sine(30), 512);
    chk("model_sin45", model_sine(45), 724);
    chk("model_sin60", model_sine(60), 887);
    chk("model_sin90", model_sine(90), 1024);
    chk("model_y_45_1365", model_y(45, 1365), 965);
    chk("model_y_bad", model_y(91, 1024), 0);

    run_one("basic", 30, 1024, 512, 0);
`ifdef SNELL_ROUND_EN
    run_one("round", 60, 1536, 1331, 0);
`else
    run_one("round", 60, 1536, 1330, 0);
`endif
    run_one("full", 90, 8191, 8191, 0);
    run_one("zero", 0, 1365, 0, 0);
    run_one("err91", 91, 1024, 0, 1);
    run_one("after_err", 90, 1024, 1024, 0);
    run_one("err127", 127, 8191, 0, 1);

    // start held high: results every 13 cycles
    wait_idle();
    theta = 7'd45; n1 = 13'd1365; start = 1'b1;
    v1 = -1; v2 = -1; nv = 0; y1 = -1; y2 = -1;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (valid) begin
        nv++;
        if (v1 < 0) begin v1 = k; y1 = y; end
        else if (v2 < 0) begin v2 = k; y2 = y; end
      end
    end
    start = 1'b0;
    chk("hold_count", nv, 2);
    chk("hold_first", v1, 12);
    chk("hold_spacing", v2 - v1, 13);
    chk("hold_y1", y1, 965);
    chk("hold_y2", y2, 965);
    wait_idle();

    // start while busy with other operands is dropped
    issue(30, 1024);
    repeat (3) tick();
    theta = 7'd90; n1 = 13'd8191; start = 1'b1;
    tick(); tick();
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (valid) begin lat = k; break; end
    end
    chk("ignore_lat", lat, 7);
    chk("ignore_y", y, 512);
    chk("ignore_err", ang_err, 0);
    wait_idle();

    // asynchronous reset in the middle of a computation
    issue(90, 1536);
    repeat (4) tick();
    #2 rst = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", valid, 0);
    chk("midrst_y", y, 0);
    tick(); tick();
    rst = 1'b1;
    nv = 0;
    for (int k = 0; k < 20; k++) begin tick(); if (valid) nv++; end
    chk("midrst_no_valid", nv, 0);
    run_one("post_rst", 30, 1024, 512, 0);

    // random traffic, checked by the scoreboard
    for (int k = 0; k < 800; k++) begin
      start = ($urandom_range(0, 3) == 0);
      theta = 7'($urandom_range(0, 100));
      if ($urandom_range(0, 9) == 0) theta = 7'($urandom_range(91, 127));
      n1 = 13'($urandom);
      tick();
    end
    start = 1'b0;
    wait_idle();
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
